// File: rtl/logic_unit_acc.sv
// Registered bitwise logic unit with accumulator and valid/ready handshake.
// Optional LOGIC_UNIT_FLAGS_EN adds registered out_zero/out_parity outputs.
module logic_unit_acc #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_acc,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [CNT_W-1:0] out_beats
`ifdef LOGIC_UNIT_FLAGS_EN
    ,
    output logic             out_zero,
    output logic             out_parity
`endif
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] result;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             xfer;

    assign in_ready = reset_n & (~out_valid | out_ready);
    assign xfer     = in_valid & in_ready;
    assign opa      = in_acc ? acc : in_a;
    // Counter sticks at all-ones instead of wrapping
    assign cnt_inc  = (&cnt) ? cnt : cnt + CNT_W'(1);

    always_comb begin
        result = '0;
        unique case (in_op)
            3'd0: result = opa & in_b;
            3'd1: result = opa | in_b;
            3'd2: result = opa ^ in_b;
            3'd3: result = ~(opa & in_b);
            3'd4: result = ~(opa | in_b);
            3'd5: result = ~(opa ^ in_b);
            3'd6: result = ~opa;
            3'd7: result = in_b;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            out_beats  <= '0;
            acc        <= '0;
            cnt        <= '0;
`ifdef LOGIC_UNIT_FLAGS_EN
            out_zero   <= 1'b0;
            out_parity <= 1'b0;
`endif
        end else if (xfer) begin
            out_valid  <= 1'b1;
            out_data   <= result;
            out_last   <= in_last;
            out_beats  <= cnt_inc;
            acc        <= in_last ? '0 : result;
            cnt        <= in_last ? '0 : cnt_inc;
`ifdef LOGIC_UNIT_FLAGS_EN
            out_zero   <= (result == '0);
            out_parity <= ^result;
`endif
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_logic_unit_acc.sv
// Self-checking bench for logic_unit_acc: directed scenarios plus
// randomized handshake traffic against a behavioural model.
module tb_logic_unit_acc;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic [2:0]  in_op = '0;
    logic        in_acc = 1'b0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_last;
    logic [7:0]  out_beats;
    logic        s_in_ready;
    logic        s_out_valid;
    logic [15:0] s_out_data;
    logic        s_out_last;
    logic [1:0]  s_out_beats;
`ifdef LOGIC_UNIT_FLAGS_EN
    logic        out_zero, out_parity;
    logic        s_out_zero, s_out_parity;
`endif

    int n_checks = 0;
    int n_fail = 0;

    // model state
    bit          m_valid;
    logic [15:0] m_data;
    bit          m_last;
    int          m_beats;
    logic [15:0] m_acc;
    int          m_cnt;
    bit          m_zero;
    bit          m_par;

    always #5 clk = ~clk;

    logic_unit_acc #(.WIDTH(16), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .in_acc(in_acc), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .out_beats(out_beats)
`ifdef LOGIC_UNIT_FLAGS_EN
        , .out_zero(out_zero), .out_parity(out_parity)
`endif
    );

    logic_unit_acc #(.WIDTH(16), .CNT_W(2)) dut_sat (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .in_acc(in_acc), .in_last(in_last),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_data(s_out_data), .out_last(s_out_last),
        .out_beats(s_out_beats)
`ifdef LOGIC_UNIT_FLAGS_EN
        , .out_zero(s_out_zero), .out_parity(s_out_parity)
`endif
    );

    function automatic logic [15:0] f_op(int op, logic [15:0] a, logic [15:0] b);
        case (op)
            0: return a & b;
            1: return a | b;
            2: return a ^ b;
            3: return ~(a & b);
            4: return ~(a | b);
            5: return ~(a ^ b);
            6: return ~a;
            default: return b;
        endcase
    endfunction

    task automatic m_reset();
        m_valid = 0; m_data = '0; m_last = 0; m_beats = 0;
        m_acc = '0; m_cnt = 0; m_zero = 0; m_par = 0;
    endtask

    // advance model on the upcoming edge, then sample 1ns after it
    task automatic tick();
        logic [15:0] r;
        bit x;
        x = in_valid && (!m_valid || out_ready);
        if (x) begin
            r = f_op(int'(in_op), in_acc ? m_acc : in_a, in_b);
            m_valid = 1;
            m_data = r;
            m_last = in_last;
            m_beats = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
            m_zero = (r == 16'h0);
            m_par = ^r;
            m_acc = in_last ? 16'h0 : r;
            m_cnt = in_last ? 0 : m_beats;
        end else if (out_ready) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic beat(int op, logic [15:0] a, logic [15:0] b, bit acc, bit last);
        in_valid = 1; in_op = op[2:0]; in_a = a; in_b = b;
        in_acc = acc; in_last = last;
        tick();
        in_valid = 0;
    endtask

    task automatic test_reset();
        reset_n = 0; out_ready = 1; in_valid = 1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_checks++;
        if (out_data !== 16'h0) begin n_fail++; $display("FAIL reset_data got %h want 0000", out_data); end
        n_checks++;
        if (out_beats !== 8'h0) begin n_fail++; $display("FAIL reset_beats got %0d want 0", out_beats); end
        n_checks++;
        if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got %b want 0", out_last); end
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", in_ready); end
        in_valid = 0;
        reset_n = 1;
        m_reset();
        tick();
    endtask

    task automatic test_single();
        beat(0, 16'h3CC3, 16'h0FF0, 0, 1);
        n_checks++;
        if (out_data !== 16'h0CC0) begin n_fail++; $display("FAIL single1_data got %h want 0cc0", out_data); end
        n_checks++;
        if (out_valid !== 1'b1 || out_beats !== 8'd1 || out_last !== 1'b1) begin
            n_fail++;
            $display("FAIL single1_ctl got v%b b%0d l%b want v1 b1 l1", out_valid, out_beats, out_last);
        end
        beat(0, 16'h1234, 16'h9876, 0, 1);
        n_checks++;
        if (out_data !== m_data) begin n_fail++; $display("FAIL single2_data got %h want %h", out_data, m_data); end
    endtask

    task automatic test_op_sweep();
        logic [15:0] tbl [8];
        tbl = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                16'h0000, 16'h0000, 16'h5555, 16'h5555};
        for (int op = 0; op < 8; op++) begin
            beat(op, 16'hAAAA, 16'h5555, 0, 1);
            n_checks++;
            if (out_data !== tbl[op]) begin
                n_fail++;
                $display("FAIL sweep_op%0d got %h want %h", op, out_data, tbl[op]);
            end
        end
    endtask

    task automatic test_accumulate();
        beat(0, 16'hFFFF, 16'hF0F0, 0, 0);
        n_checks++;
        if (out_data !== 16'hF0F0) begin n_fail++; $display("FAIL acc1 got %h want f0f0", out_data); end
        beat(0, 16'h0000, 16'h3C3C, 1, 0);
        n_checks++;
        if (out_data !== 16'h3030) begin n_fail++; $display("FAIL acc2 got %h want 3030", out_data); end
        beat(0, 16'h0000, 16'hFF00, 1, 1);
        n_checks++;
        if (out_data !== 16'h3000 || out_beats !== 8'd3 || out_last !== 1'b1) begin
            n_fail++;
            $display("FAIL acc3 got %h b%0d l%b want 3000 b3 l1", out_data, out_beats, out_last);
        end
        beat(1, 16'hFFFF, 16'h0001, 1, 1);
        n_checks++;
        if (out_data !== 16'h0001) begin n_fail++; $display("FAIL acc_clear got %h want 0001", out_data); end
    endtask

    task automatic test_backpressure();
        out_ready = 1;
        beat(0, 16'h3CC3, 16'h0FF0, 0, 1);
        out_ready = 0;
        in_valid = 1; in_op = 3'd0; in_a = 16'h1234; in_b = 16'h9876;
        in_acc = 0; in_last = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready%0d got %b want 0", i, in_ready); end
            tick();
            n_checks++;
            if (out_data !== 16'h0CC0 || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold%0d got %h v%b want 0cc0 v1", i, out_data, out_valid);
            end
        end
        out_ready = 1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got %b want 1", in_ready); end
        tick();
        in_valid = 0;
        n_checks++;
        if (out_data !== m_data || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_next got %h v%b want %h v1", out_data, out_valid, m_data);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        beat(0, 16'hFFFF, 16'hF0F0, 0, 0);
        beat(0, 16'h0000, 16'h3C3C, 1, 0);
        out_ready = 0;
        reset_n = 0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0) begin
            n_fail++;
            $display("FAIL rmid_clear got v%b %h want v0 0000", out_valid, out_data);
        end
        #1;
        reset_n = 1;
        m_reset();
        out_ready = 1;
        beat(1, 16'hFFFF, 16'h0001, 1, 0);
        n_checks++;
        if (out_data !== 16'h0001 || out_beats !== 8'd1) begin
            n_fail++;
            $display("FAIL rmid_next got %h b%0d want 0001 b1", out_data, out_beats);
        end
        beat(7, 16'h0, 16'h0, 0, 1);
    endtask

    task automatic test_saturation();
        int want;
        for (int i = 0; i < 5; i++) begin
            beat(7, 16'h0, 16'(i), 0, 0);
            want = (i + 1 > 3) ? 3 : i + 1;
            n_checks++;
            if (int'(s_out_beats) !== want) begin
                n_fail++;
                $display("FAIL sat_beat%0d got %0d want %0d", i, s_out_beats, want);
            end
            n_checks++;
            if (int'(out_beats) !== m_beats) begin
                n_fail++;
                $display("FAIL cnt8_beat%0d got %0d want %0d", i, out_beats, m_beats);
            end
        end
        beat(7, 16'h0, 16'h0, 0, 1);
    endtask

`ifdef LOGIC_UNIT_FLAGS_EN
    task automatic test_flags();
        beat(0, 16'h0000, 16'hFFFF, 0, 1);
        n_checks++;
        if (out_zero !== 1'b1 || out_parity !== 1'b0) begin
            n_fail++;
            $display("FAIL flags_zero got z%b p%b want z1 p0", out_zero, out_parity);
        end
        beat(7, 16'h0000, 16'h0007, 0, 1);
        n_checks++;
        if (out_zero !== 1'b0 || out_parity !== 1'b1) begin
            n_fail++;
            $display("FAIL flags_par got z%b p%b want z0 p1", out_zero, out_parity);
        end
    endtask
`endif

    task automatic test_random();
        bit exp_ready;
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_op = 3'($urandom_range(0, 7));
            in_a = 16'($urandom);
            in_b = 16'($urandom);
            in_acc = 1'($urandom_range(0, 1));
            in_last = ($urandom_range(0, 5) == 0);
            #1;
            exp_ready = !m_valid || out_ready;
            n_checks++;
            if (in_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL rnd_ready%0d got %b want %b", i, in_ready, exp_ready);
            end
            tick();
            n_checks++;
            if (out_valid !== m_valid) begin
                n_fail++;
                $display("FAIL rnd_valid%0d got %b want %b", i, out_valid, m_valid);
            end
            if (m_valid) begin
                n_checks++;
                if (out_data !== m_data || out_last !== m_last || int'(out_beats) !== m_beats) begin
                    n_fail++;
                    $display("FAIL rnd_out%0d got %h l%b b%0d want %h l%b b%0d",
                             i, out_data, out_last, out_beats, m_data, m_last, m_beats);
                end
`ifdef LOGIC_UNIT_FLAGS_EN
                n_checks++;
                if (out_zero !== m_zero || out_parity !== m_par) begin
                    n_fail++;
                    $display("FAIL rnd_flags%0d got z%b p%b want z%b p%b",
                             i, out_zero, out_parity, m_zero, m_par);
                end
`endif
            end
        end
        in_valid = 0;
        out_ready = 1;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();
        test_reset();
        test_single();
        test_op_sweep();
        test_accumulate();
        test_backpressure();
        test_reset_mid();
        test_saturation();
`ifdef LOGIC_UNIT_FLAGS_EN
        test_flags();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
